// File: rtl/csrng_state_db_wr_arb.sv
// Round-robin arbiter for the CSRNG state-database write port. Grants are
// registered toward the database and tagged so status acks return to the issuer.
module csrng_state_db_wr_arb #(
  parameter int NReq    = 2,
  parameter int StateId = 4,
  parameter int KeyLen  = 256,
  parameter int BlkLen  = 128,
  parameter int CtrLen  = 32,
  parameter int Cmd     = 3,
  localparam int PlW    = StateId + 1 + Cmd + KeyLen + BlkLen + CtrLen + 1,
  localparam int IdxW   = $clog2(NReq)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [NReq-1:0]       req_i,
  output logic [NReq-1:0]       rdy_o,
  input  logic [NReq*PlW-1:0]   pl_i,
  output logic                  db_wr_req_o,
  input  logic                  db_wr_req_rdy_i,
  output logic [PlW-1:0]        db_pl_o,
  input  logic                  db_sts_ack_i,
  input  logic                  db_sts_sts_i,
  input  logic [StateId-1:0]    db_sts_id_i,
  output logic [NReq-1:0]       sts_ack_o,
  output logic                  sts_sts_o,
  output logic [StateId-1:0]    sts_id_o,
  output logic                  err_o
);

  logic            out_vld_q, out_vld_d;
  logic [PlW-1:0]  out_pl_q, out_pl_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [1:0]      tag_cnt_q, tag_cnt_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] tag_mem [2];

  logic            found;
  logic [IdxW-1:0] winner;
  logic            can_load, grant, pop;
  logic [IdxW-1:0] head;
  int              idx;

  // Search from the round-robin pointer upward, wrapping at NReq.
  // NOTE: always_comb uses blocking assignments and gives every output a
  // default first, so no latch can be inferred on any path.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NReq; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NReq) idx = idx - NReq;
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = IdxW'(idx);
      end
    end
  end

  // A full tag FIFO may still accept when an ack frees a slot this cycle.
  assign can_load = (!out_vld_q || db_wr_req_rdy_i) &&
                    (tag_cnt_q < 2'd2 || db_sts_ack_i) && enable_i;
  assign grant    = can_load && found;
  assign pop      = db_sts_ack_i && enable_i && (tag_cnt_q != 2'd0);
  assign head     = tag_mem[rd_ptr_q];

  assign rdy_o       = grant ? (NReq'(1) << winner) : '0;
  assign db_wr_req_o = out_vld_q;
  assign db_pl_o     = out_pl_q;
  assign sts_ack_o   = pop ? (NReq'(1) << head) : '0;
  assign sts_sts_o   = pop && db_sts_sts_i;
  assign sts_id_o    = pop ? db_sts_id_i : '0;
  assign err_o       = err_q;

  always_comb begin
    out_vld_d = out_vld_q;
    out_pl_d  = out_pl_q;
    rr_d      = rr_q;
    tag_cnt_d = tag_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_d     = err_q;
    if (!enable_i) begin
      out_vld_d = 1'b0;
      rr_d      = '0;
      tag_cnt_d = '0;
      wr_ptr_d  = 1'b0;
      rd_ptr_d  = 1'b0;
      err_d     = 1'b0;
    end else begin
      if (grant) begin
        out_vld_d = 1'b1;
        out_pl_d  = pl_i[int'(winner)*PlW +: PlW];
        rr_d      = (winner == IdxW'(NReq-1)) ? '0 : winner + IdxW'(1);
      end else if (out_vld_q && db_wr_req_rdy_i) begin
        out_vld_d = 1'b0;
      end
      wr_ptr_d = wr_ptr_q ^ grant;
      rd_ptr_d = rd_ptr_q ^ pop;
      if (grant && !pop)      tag_cnt_d = tag_cnt_q + 2'd1;
      else if (!grant && pop) tag_cnt_d = tag_cnt_q - 2'd1;
      if (db_sts_ack_i && tag_cnt_q == 2'd0) err_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q <= 1'b0;
      out_pl_q  <= '0;
      rr_q      <= '0;
      tag_cnt_q <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      out_pl_q  <= out_pl_d;
      rr_q      <= rr_d;
      tag_cnt_q <= tag_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_q     <= err_d;
    end
  end

  // NOTE: tag storage is left unreset; an entry is only read once tag_cnt_q
  // says it was written, so a reset would add flops without changing behaviour.
  always_ff @(posedge clk_i) begin
    if (grant) tag_mem[wr_ptr_q] <= winner;
  end

endmodule

// File: tb/tb_csrng_state_db_wr_arb.sv
// Directed bench for csrng_state_db_wr_arb: single write, round-robin order,
// backpressure, full tag FIFO, spurious ack and flush.
module tb_csrng_state_db_wr_arb;
  localparam int NReq = 2;
  localparam int SId  = 4;
  localparam int PLW  = 4 + 1 + 3 + 256 + 128 + 32 + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [NReq-1:0]   req;
  logic [NReq-1:0]   rdy;
  logic [NReq*PLW-1:0] pl;
  logic              db_req;
  logic              db_rdy;
  logic [PLW-1:0]    db_pl;
  logic              ack;
  logic              ack_sts;
  logic [SId-1:0]    ack_id;
  logic [NReq-1:0]   sts_ack;
  logic              sts_sts;
  logic [SId-1:0]    sts_id;
  logic              err;

  int errors = 0;
  int checks = 0;

  logic [PLW-1:0] pl_a, pl_b;

  csrng_state_db_wr_arb dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .req_i(req), .rdy_o(rdy), .pl_i(pl),
    .db_wr_req_o(db_req), .db_wr_req_rdy_i(db_rdy), .db_pl_o(db_pl),
    .db_sts_ack_i(ack), .db_sts_sts_i(ack_sts), .db_sts_id_i(ack_id),
    .sts_ack_o(sts_ack), .sts_sts_o(sts_sts), .sts_id_o(sts_id),
    .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [PLW-1:0] mk_pl(input logic [3:0] id, input logic [31:0] s);
    return {id, 1'b1, 3'd2, {8{s}}, {4{~s}}, s, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pl_a = mk_pl(4'd3, 32'h1111_0001);
    pl_b = mk_pl(4'd9, 32'hA5A5_0002);
    pl      = {pl_b, pl_a};
    rst_n   = 1'b0;
    enable  = 1'b0;
    req     = 2'b11;
    db_rdy  = 1'b1;
    ack     = 1'b0;
    ack_sts = 1'b0;
    ack_id  = '0;

    // Reset state
    #12;
    check("rst_rdy", rdy, 0);
    check("rst_db_req", db_req, 0);
    check("rst_db_pl", db_pl, 0);
    check("rst_sts_ack", sts_ack, 0);
    check("rst_sts_sts", sts_sts, 0);
    check("rst_sts_id", sts_id, 0);
    check("rst_err", err, 0);
    rst_n  = 1'b1;

    // Single request from requester 0
    enable = 1'b1;
    req    = 2'b01;
    #1 check("single_rdy", rdy, 2'b01);
    tick();
    req = 2'b00;
    #1;
    check("single_db_req", db_req, 1);
    check("single_db_pl", db_pl, pl_a);
    tick();
    ack = 1'b1; ack_id = 4'd3; ack_sts = 1'b1;
    #1;
    check("single_sts_ack", sts_ack, 2'b01);
    check("single_sts_id", sts_id, 4'd3);
    check("single_sts_sts", sts_sts, 1);
    check("single_db_idle", db_req, 0);
    tick();
    ack = 1'b0; ack_sts = 1'b0;
    #1;
    check("single_sts_clr", sts_ack, 0);
    check("single_err", err, 0);

    // Flush to restart round-robin at requester 0
    enable = 1'b0;
    tick();
    enable = 1'b1;

    // Round-robin: both request for 6 cycles, ack two cycles after grant
    for (int c = 0; c < 8; c++) begin
      req    = (c < 6) ? 2'b11 : 2'b00;
      ack    = (c >= 2);
      ack_id = 4'(c);
      #1;
      check($sformatf("rr_rdy_c%0d", c), rdy, (c < 6) ? (2'b01 << (c % 2)) : 2'b00);
      check($sformatf("rr_ack_c%0d", c), sts_ack, (c >= 2) ? (2'b01 << ((c - 2) % 2)) : 2'b00);
      check($sformatf("rr_id_c%0d", c), sts_id, (c >= 2) ? c : 0);
      check($sformatf("rr_db_req_c%0d", c), db_req, (c >= 1 && c < 7));
      if (c >= 1 && c < 7)
        check($sformatf("rr_db_pl_c%0d", c), db_pl, ((c - 1) % 2 == 0) ? pl_a : pl_b);
      tick();
    end
    ack = 1'b0; ack_id = '0;

    // Backpressure
    req = 2'b11;
    #1 check("bp_first_grant", rdy, 2'b01);
    tick();
    db_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("bp_rdy_c%0d", c), rdy, 2'b00);
      check($sformatf("bp_pl_c%0d", c), db_pl, pl_a);
      check($sformatf("bp_req_c%0d", c), db_req, 1);
      tick();
    end
    db_rdy = 1'b1;
    #1 check("bp_release_grant", rdy, 2'b10);
    tick();
    #1;
    check("bp_next_pl", db_pl, pl_b);

    // Tag FIFO full: two tags outstanding, no ack
    check("full_no_grant", rdy, 2'b00);
    tick();
    #1 check("full_no_grant2", rdy, 2'b00);
    ack = 1'b1; ack_id = 4'd5; ack_sts = 1'b0;
    #1;
    check("full_ack_grant", rdy, 2'b01);
    check("full_ack_route", sts_ack, 2'b01);
    check("full_ack_id", sts_id, 4'd5);
    tick();
    ack = 1'b0;
    #1;
    check("full_still_two", rdy, 2'b00);
    check("full_db_pl", db_pl, pl_a);
    req = 2'b00; ack = 1'b1; ack_id = 4'd6;
    #1 check("drain_ack1", sts_ack, 2'b10);
    tick();
    #1 check("drain_ack2", sts_ack, 2'b01);
    tick();
    ack = 1'b0;
    #1 check("drain_err", err, 0);

    // Spurious ack
    tick();
    ack = 1'b1; ack_id = 4'd7; ack_sts = 1'b1;
    #1;
    check("spur_no_ack", sts_ack, 2'b00);
    check("spur_no_id", sts_id, 0);
    check("spur_no_sts", sts_sts, 0);
    tick();
    ack = 1'b0;
    #1 check("spur_err_set", err, 1);
    tick();
    check("spur_err_sticky", err, 1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    #1 check("spur_err_clr", err, 0);

    // Flush with two tags outstanding and a word pending
    req = 2'b11;
    tick();
    tick();
    req = 2'b00;
    #1;
    check("flush_pre_vld", db_req, 1);
    enable = 1'b0; req = 2'b11; ack = 1'b1; ack_id = 4'd2;
    #1;
    check("flush_rdy_off", rdy, 2'b00);
    check("flush_ack_drop", sts_ack, 2'b00);
    tick();
    enable = 1'b1; req = 2'b00; ack = 1'b0;
    #1;
    check("flush_db_req", db_req, 0);
    check("flush_err_quiet", err, 0);
    ack = 1'b1;
    #1 check("flush_late_ack", sts_ack, 2'b00);
    tick();
    ack = 1'b0;
    #1 check("flush_late_err", err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/csrng_state_db_wr_arb.md
# csrng_state_db_wr_arb

Round-robin arbiter that shares the single write port of the CSRNG state database between `NReq` command-pipeline requesters, such as the command stage and the generate stage. A granted request is registered and presented to the database as one request per cycle. The arbiter tags each grant and routes the database's status acknowledgement (`sts_ack`/`sts_sts`/`sts_id`) back to the requester that issued the write. It sits between the CSRNG command pipelines and the state database write/status interface.

## Interface
- `NReq`, 2: number of write requesters; must be at least 2.
- `StateId`, 4: instance-ID width.
- `KeyLen`, 256: key width.
- `BlkLen`, 128: V width.
- `CtrLen`, 32: reseed-counter width.
- `Cmd`, 3: command-code width.
- `PlW`, derived: payload width, `StateId+1+Cmd+KeyLen+BlkLen+CtrLen+1`. Field order, MSB to LSB: `inst_id`, `fips`, `ccmd`, `key`, `v`, `res_ctr`, `sts`.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `enable_i` in 1: block enable. Low means synchronous flush.
- `req_i` in `NReq`: per-requester write request.
- `rdy_o` out `NReq`: per-requester grant. A transfer happens when `req_i[k] & rdy_o[k]`.
- `pl_i` in `NReq*PlW`: per-requester payload. Requester k occupies slice `[k*PlW +: PlW]`.
- `db_wr_req_o` out 1: write request to the state database.
- `db_wr_req_rdy_i` in 1: state database ready.
- `db_pl_o` out `PlW`: registered payload to the state database.
- `db_sts_ack_i` in 1: status acknowledgement from the state database.
- `db_sts_sts_i` in 1: returned status.
- `db_sts_id_i` in `StateId`: returned instance ID.
- `sts_ack_o` out `NReq`: per-requester acknowledgement, one-hot or zero.
- `sts_sts_o` out 1: status forwarded with `sts_ack_o`.
- `sts_id_o` out `StateId`: instance ID forwarded with `sts_ack_o`.
- `err_o` out 1: sticky protocol error.

## Operation
- **Output stage.** `out_vld` and `out_pl` registers; `db_wr_req_o = out_vld`, `db_pl_o = out_pl`.
  - A loaded word stays stable until `db_wr_req_rdy_i` is seen high while `out_vld` is set.
- **Tag FIFO.** Depth 2, holding `$clog2(NReq)`-bit requester indices.
  - Push the granted index on every grant.
  - Pop on every `db_sts_ack_i`.
  - Occupancy counter `tag_cnt` ranges 0..2.
- **Grant condition.** `can_load = (!out_vld | db_wr_req_rdy_i) & (tag_cnt < 2 | db_sts_ack_i) & enable_i`.
- **Arbitration.**
  - Round-robin pointer `rr_q` with reset value 0.
  - The winner is the first k with `req_i[k]`, searching from `rr_q` upward with wrap.
  - `rdy_o[k] = can_load & (k == winner) & req_i[k]`. `rdy_o` is combinational from `req_i` and state.
  - On a grant: `rr_q <= winner+1` (mod `NReq`), `out_pl <= pl_i[winner]`, `out_vld <= 1`, and the winner index is pushed.
  - If there is no grant and the output is consumed, `out_vld <= 0`.
- **Acknowledgement routing.**
  - When `db_sts_ack_i` is high with `tag_cnt > 0`: `sts_ack_o[head] = 1`, `sts_sts_o = db_sts_sts_i`, `sts_id_o = db_sts_id_i`. These are combinational pass-throughs.
  - When `sts_ack_o` is zero, `sts_sts_o` and `sts_id_o` are 0.
- **Errors.**
  - `db_sts_ack_i` with `tag_cnt == 0`: the ack is dropped, no pop occurs, and `err_o` sets.
  - `err_o` clears only on reset or `enable_i` low.
- **Flush.** `enable_i` low for one cycle clears `out_vld`, `tag_cnt`, the FIFO pointers, `rr_q` and `err_o`.
  - `rdy_o` is 0 while `enable_i` is low.
  - Acks arriving while `enable_i` is low are dropped without setting `err_o`.
- **Simultaneous push and pop** in one cycle leaves `tag_cnt` unchanged. When this happens at `tag_cnt == 2`, the grant is allowed.

## Timing
- **Reset values.** `rdy_o = 0`, `db_wr_req_o = 0`, `db_pl_o = 0`, `sts_ack_o = 0`, `sts_sts_o = 0`, `sts_id_o = 0`, `err_o = 0`.
- **Grant to database request.** Grant in cycle N, `db_wr_req_o` high in cycle N+1.
- **Throughput.** Sustained one write per cycle when the database acknowledges one cycle after acceptance.
- **Backpressure.** `db_wr_req_rdy_i` low holds `db_pl_o` and blocks further grants.
- **Reset mid-operation.** Asynchronous reset mid-transfer discards all state. Requesters must reissue.

## Test plan
- **Single request.** Reset, enable, `req_i = 2'b01` for one cycle with `inst_id = 3`.
  - `rdy_o = 01` in cycle 0.
  - `db_wr_req_o = 1` with `db_pl_o` equal to the payload in cycle 1.
  - `db_sts_ack_i` in cycle 2 with `db_sts_id_i = 3` produces `sts_ack_o = 01` and `sts_id_o = 3`.
- **Round-robin fairness.** Both requesters request continuously for 6 cycles with the database always ready and acking the next cycle.
  - Grants go 0, 1, 0, 1, 0, 1.
  - Each `sts_ack_o` goes to the matching requester.
- **Backpressure.** `db_wr_req_rdy_i = 0` for 4 cycles with both requesting.
  - `db_pl_o` is stable.
  - `rdy_o = 0` after the first grant.
  - On release, the next grant goes to the other requester.
- **Tag-FIFO full.** Withhold `db_sts_ack_i` after 2 accepted writes.
  - No third grant.
  - One ack together with a pending request grants in the same cycle, and `tag_cnt` stays at 2.
- **Spurious ack.** Idle bench, pulse `db_sts_ack_i`.
  - `sts_ack_o = 0` and `err_o = 1`, which stays set.
  - `enable_i` low for 1 cycle clears `err_o`.
- **Flush.** Drop `enable_i` with 2 tags outstanding and `out_vld = 1`.
  - Next cycle: `db_wr_req_o = 0` and `tag_cnt = 0`.
  - Later acks produce no `sts_ack_o`.
